// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock, MSB first.
// Start/done handshake; results and the divide-by-zero flag are held until the next completion.
module seq_divider_8by4 #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_q;
    logic [DW-1:0] w_q_nxt;
    logic [VW-1:0] r_d;
    logic [VW-1:0] w_d_nxt;
    logic [VW:0]   r_r;
    logic [VW:0]   w_r_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_quo;
    logic [DW-1:0] w_quo_nxt;
    logic [VW-1:0] r_rem;
    logic [VW-1:0] w_rem_nxt;
    logic          r_dbz;
    logic          w_dbz_nxt;
    logic          r_busy;
    logic          r_done;

    logic [VW:0]   w_t;
    logic          w_ge;
    logic [VW:0]   w_r_iter;
    logic [DW-1:0] w_q_iter;

    // One restoring step: shift next dividend bit into R, subtract D when it fits.
    assign w_t      = (VW + 1)'({r_r, r_q[DW-1]});
    assign w_ge     = (w_t >= {1'b0, r_d});
    assign w_r_iter = w_ge ? (w_t - {1'b0, r_d}) : w_t;
    assign w_q_iter = {r_q[DW-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_r_nxt     = r_r;
        w_cnt_nxt   = r_cnt;
        w_quo_nxt   = r_quo;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_q_nxt   = dividend;
                    w_d_nxt   = divisor;
                    w_r_nxt   = '0;
                    w_cnt_nxt = '0;
                    if (divisor == '0) begin
                        // Divide-by-zero skips the iterations and reports saturated quotient.
                        w_state_nxt = S_DONE;
                        w_quo_nxt   = {DW{1'b1}};
                        w_rem_nxt   = dividend[VW-1:0];
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_q_nxt   = w_q_iter;
                w_r_nxt   = w_r_iter;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(DW - 1)) begin
                    w_state_nxt = S_DONE;
                    w_quo_nxt   = w_q_iter;
                    w_rem_nxt   = w_r_iter[VW-1:0];
                    w_dbz_nxt   = 1'b0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // busy/done are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_r     <= w_r_nxt;
            r_cnt   <= w_cnt_nxt;
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
